branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the pipelined RISC-V core: a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters.
- IF stage looks up the current PC and gets a predicted direction and next PC in the same cycle.
- EX stage writes back resolved branch outcomes.
- Keeps saturating lookup and mispredict statistics for the testbench.

Parameters:
- XLEN, 64, address/data width.
- ENTRIES, 16, BTB entries; power of 2, at least 2.
- TAG_W, 10, tag bits stored per entry.
- CNT_W, 32, width of the statistics counters.
- CTR_INIT, 2'b01, counter value after reset or flush (weakly not-taken).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; reset=0 at a rising edge clears state.
- lookup_valid  in  1  IF stage presents a PC this cycle.
- lookup_pc  in  XLEN  IF-stage PC.
- pred_hit  out  1  BTB entry is valid and tag matches.
- pred_taken  out  1  predicted taken.
- pred_target  out  XLEN  predicted next PC.
- upd_valid  in  1  EX stage resolved a branch this cycle.
- upd_pc  in  XLEN  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  XLEN  actual taken target.
- upd_pred_taken  in  1  prediction that was carried down the pipe with the branch.
- upd_pred_target  in  XLEN  predicted target that was carried down the pipe with the branch.
- flush_all  in  1  invalidate every BTB entry.
- mispredict  out  1  combinational; the current update is a misprediction.
- lookup_count  out  CNT_W  number of lookups.
- mispredict_count  out  CNT_W  number of mispredictions.

Behaviour:
- Indexing:
  - IDX_W = clog2(ENTRIES).
  - index = pc[IDX_W+1:2].
  - tag = pc[IDX_W+2 +: TAG_W].
  - Bits [1:0] are ignored.
- Lookup (combinational, zero latency):
  - pred_hit = valid[idx] && tag[idx]==lookup tag.
  - pred_taken = pred_hit && ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : lookup_pc+4, with XLEN-bit wrap-around.
  - Lookup outputs are independent of lookup_valid.
- Update (registered, visible the cycle after upd_valid):
  - Hit: ctr saturating +1 if taken, -1 if not-taken, bounded 00..11. If taken, target is overwritten with upd_target.
  - Miss and taken: allocate the entry. Set valid=1, tag, target=upd_target, ctr=2'b10. Any previous occupant is replaced.
  - Miss and not-taken: no state change.
- No bypass: a lookup and an update to the same index in the same cycle return pre-update contents.
- mispredict = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_pred_target != upd_target)).
- Statistics:
  - lookup_count increments when lookup_valid is high.
  - mispredict_count increments when mispredict is high.
  - Both saturate at 2^CNT_W-1 and never wrap.
- flush_all:
  - Next edge: all valid=0 and all ctr=CTR_INIT.
  - Statistics are untouched.
  - flush_all wins over a simultaneous upd_valid; that update is dropped, but mispredict_count still counts it.
- Reset (reset=0 at an edge):
  - All valid=0, ctr=CTR_INIT, target=0, tags=0.
  - Both statistics counters = 0.
  - Reset has priority over flush_all and updates.
  - Reset mid-stream discards all learned state.
  - While reset is low, outputs follow the lookup rules on the cleared state: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.
- Storage is plain flops/registers; no memory macro is assumed.

Decomposition:
- Package bp_pkg holds:
  - counter encodings: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
  - the ALLOC_CTR constant (=WT);
  - a saturating 2-bit inc/dec function;
  - index/tag extraction functions parametrised by IDX_W and TAG_W.
- One sub-module, bp_stat_counter: a CNT_W-bit saturating event counter with synchronous active-low clear. It is instantiated twice.
- The BTB arrays and lookup/update logic stay in branch_predictor.

Test Plan:
- Configuration for all scenarios: ENTRIES=16, TAG_W=10.
- Cold lookup: after reset, lookup_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x44.
- Allocate and hysteresis:
  - Update pc=0x40, taken, target=0x10; next cycle lookup 0x40 -> hit=1, taken=1, target=0x10.
  - One not-taken update -> taken=0 (ctr 01), hit still 1.
  - Second not-taken update -> ctr 00; a not-taken update at 00 stays 00.
- Saturation: three taken updates to 0x40 -> ctr 11; one not-taken -> ctr 10, still predicts taken to 0x10.
- Aliasing: with 0x40 allocated (idx 0, tag 0x1), lookup 0x440 (idx 0, tag 0x11) -> hit=0, target=0x444. Taken update 0x440 -> 0x200 replaces the entry; lookup 0x40 then misses.
- Mispredict stats: update with upd_taken=1, upd_pred_taken=1, upd_pred_target=0x10, upd_target=0x20 -> mispredict=1, mispredict_count increments by 1. 100 lookups with lookup_valid high -> lookup_count=100.
- Flush vs reset:
  - flush_all with a simultaneous taken update -> all lookups miss, counts preserved, mispredict_count still increments if that update mispredicts.
  - Then reset=0 for one edge -> both counts=0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: counter encodings,
// saturating counter step and PC index/tag extraction.
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [1:0] ALLOC_CTR = WT;

    // Widest PC the extraction helpers accept; callers zero-extend into it.
    localparam int MAX_XLEN = 128;

    function automatic logic [1:0] ctr_next(
        input logic [1:0] c,
        input logic       taken
    );
        if (taken)
            return (c == ST) ? ST : c + 2'd1;
        else
            return (c == SNT) ? SNT : c - 2'd1;
    endfunction

    function automatic logic [31:0] pc_index(
        input logic [MAX_XLEN-1:0] pc,
        input int                  idx_w
    );
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++)
            if (i < idx_w)
                r[i] = pc[i+2];
        return r;
    endfunction

    function automatic logic [31:0] pc_tag(
        input logic [MAX_XLEN-1:0] pc,
        input int                  idx_w,
        input int                  tag_w
    );
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++)
            if (i < tag_w && (idx_w + 2 + i) < MAX_XLEN)
                r[i] = pc[idx_w+2+i];
        return r;
    endfunction

endpackage

// File: rtl/bp_stat_counter.sv
// Saturating event counter with synchronous active-low clear.
module bp_stat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!clr_n)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: zero-latency IF
// lookup, registered EX update, and lookup/mispredict statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int         XLEN     = 64,
    parameter int         ENTRIES  = 16,
    parameter int         TAG_W    = 10,
    parameter int         CNT_W    = 32,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lookup_valid,
    input  logic [XLEN-1:0]  lookup_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_pred_taken,
    input  logic [XLEN-1:0]  upd_pred_target,
    input  logic             flush_all,
    output logic             mispredict,
    output logic [CNT_W-1:0] lookup_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [XLEN-1:0]  tgt_q   [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             upd_hit;

    always_comb begin
        lk_idx = IDX_W'(pc_index(MAX_XLEN'(lookup_pc), IDX_W));
        lk_tag = TAG_W'(pc_tag(MAX_XLEN'(lookup_pc), IDX_W, TAG_W));
        up_idx = IDX_W'(pc_index(MAX_XLEN'(upd_pc), IDX_W));
        up_tag = TAG_W'(pc_tag(MAX_XLEN'(upd_pc), IDX_W, TAG_W));
    end

    always_comb begin
        pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = pred_hit && ctr_q[lk_idx][1];
        pred_target = pred_taken ? tgt_q[lk_idx]
                                 : lookup_pc + XLEN'(4);
        upd_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    end

    assign mispredict = upd_valid &&
        ((upd_taken != upd_pred_taken) ||
         (upd_taken && (upd_pred_target != upd_target)));

    // Flush drops a same-cycle update; reset overrides both.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= CTR_INIT;
            end
        end else if (flush_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_INIT;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                ctr_q[up_idx] <= ctr_next(ctr_q[up_idx], upd_taken);
                if (upd_taken)
                    tgt_q[up_idx] <= upd_target;
            end else if (upd_taken) begin
                valid_q[up_idx] <= 1'b1;
                tag_q[up_idx]   <= up_tag;
                tgt_q[up_idx]   <= upd_target;
                ctr_q[up_idx]   <= ALLOC_CTR;
            end
        end
    end

    bp_stat_counter #(.CNT_W(CNT_W)) u_lookup_cnt (
        .clk   (clk),
        .clr_n (reset),
        .inc   (lookup_valid),
        .count (lookup_count)
    );

    bp_stat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
        .clk   (clk),
        .clr_n (reset),
        .inc   (mispredict),
        .count (mispredict_count)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed vector table, corner-case
// sequences, and randomized traffic against a behavioural model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic        lookup_valid;
    logic [63:0] lookup_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [63:0] pred_target;
    logic        upd_valid;
    logic [63:0] upd_pc;
    logic        upd_taken;
    logic [63:0] upd_target;
    logic        upd_pred_taken;
    logic [63:0] upd_pred_target;
    logic        flush_all;
    logic        mispredict;
    logic [31:0] lookup_count;
    logic [31:0] mispredict_count;

    always #5 clk = ~clk;

    branch_predictor #(
        .XLEN(64), .ENTRIES(16), .TAG_W(10), .CNT_W(32), .CTR_INIT(2'b01)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .lookup_valid     (lookup_valid),
        .lookup_pc        (lookup_pc),
        .pred_hit         (pred_hit),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_taken   (upd_pred_taken),
        .upd_pred_target  (upd_pred_target),
        .flush_all        (flush_all),
        .mispredict       (mispredict),
        .lookup_count     (lookup_count),
        .mispredict_count (mispredict_count)
    );

    // Behavioural model: one record per BTB slot, counter as an integer 0..3.
    bit          m_valid [16];
    int          m_tag   [16];
    logic [63:0] m_tgt   [16];
    int          m_ctr   [16];
    longint      m_lk;
    longint      m_mp;
    int          n_checks = 0;
    int          n_err = 0;

    typedef struct {
        bit          do_upd;
        logic [63:0] upd_pc;
        bit          taken;
        logic [63:0] utgt;
        logic [63:0] lk_pc;
        bit          hit;
        bit          tk;
        logic [63:0] tgt;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int slot_of(input logic [63:0] pc);
        return int'((pc >> 2) % 64'd16);
    endfunction

    function automatic int tag_of(input logic [63:0] pc);
        return int'((pc >> 6) % 64'd1024);
    endfunction

    task automatic model_pred(input logic [63:0] pc, output bit hit,
                              output bit tk, output logic [63:0] tgt);
        int s;
        s   = slot_of(pc);
        hit = m_valid[s] && m_tag[s] == tag_of(pc);
        tk  = hit && m_ctr[s] >= 2;
        tgt = tk ? m_tgt[s] : pc + 64'd4;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
    endtask

    task automatic check_lookup();
        bit          h;
        bit          t;
        logic [63:0] g;
        model_pred(lookup_pc, h, t, g);
        chk("pred_hit", 64'(pred_hit), 64'(h));
        chk("pred_taken", 64'(pred_taken), 64'(t));
        chk("pred_target", pred_target, g);
    endtask

    // One clock: advance the model from the settled inputs, then compare counts.
    task automatic tick();
        bit mp;
        int s;
        #1;
        mp = upd_valid && (upd_taken != upd_pred_taken ||
             (upd_taken && upd_pred_target != upd_target));
        if (upd_valid)
            chk("mispredict", 64'(mispredict), 64'(mp));
        if (!reset) begin
            model_clear();
            m_lk = 0;
            m_mp = 0;
        end else begin
            if (lookup_valid && m_lk < 64'hFFFF_FFFF) m_lk++;
            if (mp && m_mp < 64'hFFFF_FFFF) m_mp++;
            if (flush_all) begin
                for (int i = 0; i < 16; i++) begin
                    m_valid[i] = 0;
                    m_ctr[i]   = 1;
                end
            end else if (upd_valid) begin
                s = slot_of(upd_pc);
                if (m_valid[s] && m_tag[s] == tag_of(upd_pc)) begin
                    if (upd_taken) begin
                        if (m_ctr[s] < 3) m_ctr[s]++;
                        m_tgt[s] = upd_target;
                    end else if (m_ctr[s] > 0) begin
                        m_ctr[s]--;
                    end
                end else if (upd_taken) begin
                    m_valid[s] = 1;
                    m_tag[s]   = tag_of(upd_pc);
                    m_tgt[s]   = upd_target;
                    m_ctr[s]   = 2;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("lookup_count", 64'(lookup_count), 64'(m_lk));
        chk("mispredict_count", 64'(mispredict_count), 64'(m_mp));
    endtask

    task automatic idle_inputs();
        lookup_valid    = 0;
        upd_valid       = 0;
        upd_taken       = 0;
        upd_pred_taken  = 0;
        upd_pc          = '0;
        upd_target      = '0;
        upd_pred_target = '0;
        flush_all       = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        tick();
        tick();
        reset = 1;
    endtask

    task automatic drive_upd(input logic [63:0] pc, input bit tk,
                             input logic [63:0] tgt, input bit ptk,
                             input logic [63:0] ptgt);
        upd_valid       = 1;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
    endtask

    task automatic chk_pred(input string n, input bit h, input bit t,
                            input logic [63:0] g);
        #1;
        chk({n, "_hit"}, 64'(pred_hit), 64'(h));
        chk({n, "_taken"}, 64'(pred_taken), 64'(t));
        chk({n, "_target"}, pred_target, g);
    endtask

    initial begin
        bit          h;
        bit          t;
        logic [63:0] g;
        logic [63:0] hi;

        vecs[0]  = '{0, 64'h0,   0, 64'h0,   64'h40,  0, 0, 64'h44};
        vecs[1]  = '{1, 64'h40,  1, 64'h10,  64'h40,  1, 1, 64'h10};
        vecs[2]  = '{1, 64'h40,  0, 64'h0,   64'h40,  1, 0, 64'h44};
        vecs[3]  = '{1, 64'h40,  0, 64'h0,   64'h40,  1, 0, 64'h44};
        vecs[4]  = '{1, 64'h40,  0, 64'h0,   64'h40,  1, 0, 64'h44};
        vecs[5]  = '{1, 64'h40,  1, 64'h10,  64'h40,  1, 0, 64'h44};
        vecs[6]  = '{1, 64'h40,  1, 64'h10,  64'h40,  1, 1, 64'h10};
        vecs[7]  = '{1, 64'h40,  1, 64'h10,  64'h40,  1, 1, 64'h10};
        vecs[8]  = '{1, 64'h40,  1, 64'h10,  64'h40,  1, 1, 64'h10};
        vecs[9]  = '{1, 64'h40,  0, 64'h0,   64'h40,  1, 1, 64'h10};
        vecs[10] = '{0, 64'h0,   0, 64'h0,   64'h440, 0, 0, 64'h444};
        vecs[11] = '{1, 64'h440, 1, 64'h200, 64'h40,  0, 0, 64'h44};
        vecs[12] = '{0, 64'h0,   0, 64'h0,   64'h440, 1, 1, 64'h200};
        vecs[13] = '{0, 64'h0,   0, 64'h0,   64'hFFFF_FFFF_FFFF_FFFC,
                     0, 0, 64'h0};

        idle_inputs();
        lookup_pc = 64'h40;
        model_clear();
        m_lk = 0;
        m_mp = 0;
        do_reset();

        for (int i = 0; i < 14; i++) begin
            idle_inputs();
            if (vecs[i].do_upd)
                drive_upd(vecs[i].upd_pc, vecs[i].taken, vecs[i].utgt,
                          0, 64'h0);
            tick();
            idle_inputs();
            lookup_pc = vecs[i].lk_pc;
            chk_pred($sformatf("vec%0d", i), vecs[i].hit, vecs[i].tk,
                     vecs[i].tgt);
        end

        // Mispredict flag: wrong target, correct target, correct not-taken.
        drive_upd(64'h40, 1, 64'h20, 1, 64'h10);
        #1;
        chk("mp_wrong_target", 64'(mispredict), 64'h1);
        tick();
        chk("mp_count_one", 64'(mispredict_count), 64'(m_mp));
        drive_upd(64'h40, 1, 64'h20, 1, 64'h20);
        #1;
        chk("mp_right_target", 64'(mispredict), 64'h0);
        drive_upd(64'h40, 0, 64'h20, 0, 64'h99);
        #1;
        chk("mp_nt_ignores_tgt", 64'(mispredict), 64'h0);
        idle_inputs();
        #1;
        chk("mp_no_valid", 64'(mispredict), 64'h0);

        do_reset();
        lookup_valid = 1;
        for (int i = 0; i < 100; i++) tick();
        lookup_valid = 0;
        chk("lookup_count_100", 64'(lookup_count), 64'd100);

        // Flush with a simultaneous mispredicting taken update.
        do_reset();
        drive_upd(64'h40, 1, 64'h10, 1, 64'h10);
        tick();
        idle_inputs();
        lookup_pc = 64'h40;
        chk_pred("pre_flush", 1, 1, 64'h10);
        flush_all = 1;
        drive_upd(64'h80, 1, 64'h30, 0, 64'h0);
        tick();
        idle_inputs();
        chk("flush_mp_count", 64'(mispredict_count), 64'd1);
        chk("flush_lk_count", 64'(lookup_count), 64'd0);
        lookup_pc = 64'h40;
        chk_pred("flush_40", 0, 0, 64'h44);
        lookup_pc = 64'h80;
        chk_pred("flush_80", 0, 0, 64'h84);

        drive_upd(64'h40, 1, 64'h10, 1, 64'h10);
        lookup_valid = 1;
        tick();
        idle_inputs();
        lookup_pc = 64'h40;
        chk_pred("realloc", 1, 1, 64'h10);
        reset = 0;
        tick();
        chk_pred("in_reset", 0, 0, 64'h44);
        chk("reset_lk_count", 64'(lookup_count), 64'd0);
        chk("reset_mp_count", 64'(mispredict_count), 64'd0);
        reset = 1;

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            reset        = ($urandom_range(0, 99) != 0);
            flush_all    = ($urandom_range(0, 39) == 0);
            lookup_valid = $urandom_range(0, 1);
            hi = ($urandom_range(0, 3) == 0) ?
                 {$urandom, $urandom} << 16 : 64'h0;
            lookup_pc = hi | (64'($urandom_range(0, 2)) << 6) |
                        (64'($urandom_range(0, 15)) << 2) |
                        64'($urandom_range(0, 3));
            upd_valid = $urandom_range(0, 1);
            upd_pc = (64'($urandom_range(0, 2)) << 6) |
                     (64'($urandom_range(0, 15)) << 2) |
                     64'($urandom_range(0, 3));
            upd_taken  = $urandom_range(0, 1);
            upd_target = 64'($urandom_range(0, 7)) << 4;
            if ($urandom_range(0, 1) != 0) begin
                model_pred(upd_pc, h, t, g);
                upd_pred_taken  = t;
                upd_pred_target = g;
            end else begin
                upd_pred_taken  = $urandom_range(0, 1);
                upd_pred_target = 64'($urandom_range(0, 7)) << 4;
            end
            #1;
            check_lookup();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
